// File: rtl/aes_128_ctr.sv
// AES-128 counter-mode stream block: one 128-bit block per cycle, XORed with
// the keystream produced by a fully combinational AES-128 core.

module aes_128 (
  input  logic [127:0] in_bus,
  input  logic [127:0] key,
  output logic [127:0] out_bus
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      acc = acc ^ (b[i] ? x : 8'h00);
      x   = xtime(x);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] a2, a3, a6, a12, a15, a30, a60, a120, a240, a252;
    a2   = gf_mul(a, a);
    a3   = gf_mul(a2, a);
    a6   = gf_mul(a3, a3);
    a12  = gf_mul(a6, a6);
    a15  = gf_mul(a12, a3);
    a30  = gf_mul(a15, a15);
    a60  = gf_mul(a30, a30);
    a120 = gf_mul(a60, a60);
    a240 = gf_mul(a120, a120);
    a252 = gf_mul(a240, a12);
    return gf_mul(a252, a2);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x;
    x = gf_inv(a);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^
           {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    r = 128'h0;
    for (int i = 0; i < 16; i++) begin
      r[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    end
    return r;
  endfunction

  // Byte i of the block sits at column i/4, row i%4.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int w = 0; w < 4; w++) begin
        r[127-8*(4*c+w) -: 8] = s[127-8*(4*((c+w)%4)+w) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    r = 128'h0;
    for (int c = 0; c < 4; c++) begin
      r[127-32*c -: 32] = mix_column(s[127-32*c -: 32]);
    end
    return r;
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h000000};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Key schedule is unrolled alongside the rounds so no key state is stored.
  function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input logic [127:0] k);
    logic [127:0] st;
    logic [127:0] rk;
    logic [7:0]   rc;
    st = pt ^ k;
    rk = k;
    rc = 8'h01;
    for (int rnd = 1; rnd <= 10; rnd++) begin
      rk = next_key(rk, rc);
      rc = xtime(rc);
      st = shift_rows(sub_bytes(st));
      if (rnd < 10) begin
        st = mix_columns(st);
      end else begin
        st = st;
      end
      st = st ^ rk;
    end
    return st;
  endfunction

  assign out_bus = aes_encrypt(in_bus, key);

endmodule

module aes_128_ctr #(
  parameter int CTR_WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [127:0] key_in,
  input  logic [127:0] iv_in,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         ctr_wrap,
  output logic         keyed
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [CTR_WIDTH-1:0] CTR_ONE = {{(CTR_WIDTH-1){1'b0}}, 1'b1};

  state_t       state_r;
  state_t       state_next;
  logic [127:0] key_r;
  logic [127:0] ctr_r;
  logic [127:0] ctr_inc;
  logic [127:0] keystream;
  logic         accept;

  aes_128 u_aes (
    .in_bus  (ctr_r),
    .key     (key_r),
    .out_bus (keystream)
  );

  assign keyed    = (state_r == RUN);
  assign in_ready = (state_r == RUN) && !load && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next;
    end
  end

  // Next state: only reset leaves RUN
  always_comb begin
    state_next = state_r;
    case (state_r)
      IDLE: begin
        if (load) begin
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      RUN:     state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  // Counter increment confined to the low field
  always_comb begin
    ctr_inc = ctr_r;
    ctr_inc[CTR_WIDTH-1:0] = ctr_r[CTR_WIDTH-1:0] + CTR_ONE;
  end

  // Datapath registers; load outranks any handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      key_r     <= 128'h0;
      ctr_r     <= 128'h0;
      ctr_wrap  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 128'h0;
    end else if (load) begin
      key_r     <= key_in;
      ctr_r     <= iv_in;
      ctr_wrap  <= 1'b0;
      out_valid <= 1'b0;
    end else if (accept) begin
      out_data  <= in_data ^ keystream;
      out_valid <= 1'b1;
      ctr_r     <= ctr_inc;
      if (&ctr_r[CTR_WIDTH-1:0]) begin
        ctr_wrap <= 1'b1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/aes_128_ctr.md
AES_128_CTR -- requirements
Module: aes_128_ctr

Interface
REQ-001 Parameter CTR_WIDTH, default 32, width of the incrementing low counter field (legal 8..128).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 load  input  1  latch key_in and iv_in; (re)start stream.
REQ-005 key_in  input  128  cipher key, sampled only on load.
REQ-006 iv_in  input  128  initial counter block, sampled only on load.
REQ-007 in_valid  input  1  in_data holds a valid block.
REQ-008 in_ready  output  1  block can accept in_data this cycle.
REQ-009 in_data  input  128  plaintext/ciphertext block.
REQ-010 out_valid  output  1  out_data holds a valid result.
REQ-011 out_ready  input  1  downstream accepts out_data this cycle.
REQ-012 out_data  output  128  in_data XOR keystream block.
REQ-013 ctr_wrap  output  1  sticky flag: low counter field wrapped.
REQ-014 keyed  output  1  a key/IV has been loaded since reset.

Function
REQ-015 Block SHALL hold registered key_r[127:0] and ctr_r[127:0]; keystream = aes_128(in_bus=ctr_r, key=key_r), computed by an internal combinational aes_128 instance.
REQ-016 States SHALL be IDLE (keyed=0) and RUN (keyed=1); IDLE->RUN on load; RUN->RUN on load; only rst returns to IDLE.
REQ-017 in_ready SHALL equal (state==RUN) && !load && (!out_valid || out_ready).
REQ-018 Accept = in_valid && in_ready; on accept, out_data SHALL register in_data ^ keystream, out_valid SHALL be 1 next cycle (latency 1 cycle).
REQ-019 On accept, ctr_r[CTR_WIDTH-1:0] SHALL increment by 1 modulo 2^CTR_WIDTH; ctr_r[127:CTR_WIDTH] SHALL stay unchanged.
REQ-020 On accept where ctr_r[CTR_WIDTH-1:0] is all ones, ctr_wrap SHALL set to 1 next cycle and stay set until load or rst.
REQ-021 out_valid && !out_ready SHALL hold out_data and out_valid stable; no accept SHALL occur.
REQ-022 out_valid && out_ready with simultaneous accept SHALL replace out_data with the new result, out_valid staying 1 (full throughput, one block/cycle).
REQ-023 out_valid && out_ready without accept SHALL clear out_valid next cycle.
REQ-024 load SHALL take priority: key_r<=key_in, ctr_r<=iv_in, ctr_wrap<=0, out_valid<=0 (pending output discarded), no accept that cycle.
REQ-025 in_data while in IDLE SHALL be ignored (in_ready=0).
REQ-026 Keystream SHALL depend only on registered key_r/ctr_r, never on key_in/iv_in directly.

Reset
REQ-027 On rst: state=IDLE, keyed=0, in_ready=0, out_valid=0, out_data=0, ctr_wrap=0, key_r=0, ctr_r=0.
REQ-028 rst SHALL override load and any handshake in the same cycle.
REQ-029 rst mid-stream SHALL discard pending output; a new load is required before further accepts.

Verification
REQ-030 FIPS-197 vector: load key 000102030405060708090a0b0c0d0e0f, iv 00112233445566778899aabbccddeeff; send in_data=0 -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a one cycle after accept.
REQ-031 Same setup, 4 back-to-back blocks with out_ready=1 -> 4 consecutive out_valid cycles; block n equals model aes_128(iv+n, low 32 bits) XOR in_data.
REQ-032 Backpressure: out_ready=0 for 5 cycles with out_valid=1 -> in_ready=0, out_data unchanged; release -> stream resumes with no loss or duplication.
REQ-033 Wrap: iv low word ffffffff, one block accepted -> ctr_r low word 00000000, upper 96 bits unchanged, ctr_wrap=1; subsequent load -> ctr_wrap=0.
REQ-034 load asserted while out_valid=1, out_ready=0 -> out_valid=0 next cycle, new key/IV used for next accepted block.
REQ-035 rst asserted during streaming with load=1 -> all outputs at reset values next cycle, keyed=0, in_ready=0.
